// File: rtl/sprite_load_controller.sv
// Turns SPI sprite commands into storage write cycles (streamed load or constant fill); SPRITE_LOAD_CHECKSUM_EN adds a payload checksum.
// Latency: one write per accepted payload byte, registered one clock after data_read; fill issues one write per clock.
// Backpressure: none; data_read arriving during a fill is dropped and flagged in err_overrun.
module sprite_load_controller #(
  parameter int         SPRITE_NUM   = 16,
  parameter int         SPRITE_BYTES = 512,
  parameter int         PIXEL_BITS   = 4,
  parameter logic [7:0] CMD_SAVE     = 8'h01,
  parameter logic [7:0] CMD_CLEAR    = 8'h02,
  parameter int         ADDR_W       = $clog2(SPRITE_NUM * SPRITE_BYTES * (8 / PIXEL_BITS))
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            command,
  input  logic [7:0]            data,
  input  logic [15:0]           data_index,
  input  logic                  data_read,
  output logic                  w_en,
  output logic [ADDR_W-1:0]     w_addr,
  output logic [7:0]            w_data,
  output logic                  busy,
  output logic                  load_done,
  output logic [SPRITE_NUM-1:0] sprite_valid,
  output logic                  err_overrun,
  output logic [7:0]            load_checksum
);

  localparam int          PPB      = 8 / PIXEL_BITS;
  localparam int          STRIDE   = SPRITE_BYTES * PPB;
  localparam int          SEL_W    = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1;
  localparam logic [15:0] LAST_IDX = 16'(SPRITE_BYTES);
  localparam logic [15:0] LAST_CNT = 16'(SPRITE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR_ARG, FILL, DISCARD} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [7:0]       fill_byte;
  logic [15:0]      cnt;

  logic        cmd_ok;
  logic        sel_start;
  logic        slot_ok;
  logic [15:0] load_k;

  // Only the two known commands are ever acted on; everything else is noise on the bus.
  assign cmd_ok    = data_read && (command == CMD_SAVE || command == CMD_CLEAR);
  assign sel_start = cmd_ok && (data_index == 16'd0) && (state != FILL);
  assign slot_ok   = {24'd0, data} < 32'(SPRITE_NUM);
  assign load_k    = data_index - 16'd1;

  function automatic logic [7:0] swap_pix(input logic [7:0] b);
    return (PIXEL_BITS == 4) ? {b[3:0], b[7:4]} : b;
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [SEL_W-1:0] s, input logic [15:0] k);
    logic [31:0] a;
    a = 32'(s) * 32'(STRIDE) + 32'(k) * 32'(PPB);
    return a[ADDR_W-1:0];
  endfunction

`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [7:0] sum;
`else
  assign load_checksum = 8'd0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= '0;
      fill_byte    <= '0;
      cnt          <= '0;
      w_en         <= 1'b0;
      w_addr       <= '0;
      w_data       <= '0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      sprite_valid <= '0;
      err_overrun  <= 1'b0;
`ifdef SPRITE_LOAD_CHECKSUM_EN
      sum           <= '0;
      load_checksum <= '0;
`endif
    end else begin
      w_en      <= 1'b0;
      load_done <= 1'b0;
      if (sel_start) begin
        // Index 0 always (re)selects a slot, from any state except an active fill.
        sel <= data[SEL_W-1:0];
`ifdef SPRITE_LOAD_CHECKSUM_EN
        sum <= '0;
`endif
        if (slot_ok) begin
          if (command == CMD_SAVE) begin
            sprite_valid[data[SEL_W-1:0]] <= 1'b0;
            state <= LOAD;
          end else begin
            state <= CLEAR_ARG;
          end
        end else begin
          err_overrun <= 1'b1;
          state       <= DISCARD;
        end
      end else begin
        case (state)
          IDLE: begin
            if (cmd_ok && data_index > LAST_IDX)
              err_overrun <= 1'b1;
          end
          LOAD: begin
            if (data_read && command == CMD_SAVE && data_index != 16'd0 && data_index <= LAST_IDX) begin
              w_en   <= 1'b1;
              w_addr <= pix_addr(sel, load_k);
              w_data <= swap_pix(data);
`ifdef SPRITE_LOAD_CHECKSUM_EN
              sum <= sum + data;
`endif
              if (data_index == LAST_IDX) begin
                sprite_valid[sel] <= 1'b1;
                load_done         <= 1'b1;
                state             <= IDLE;
`ifdef SPRITE_LOAD_CHECKSUM_EN
                load_checksum <= sum + data;
`endif
              end
            end
          end
          CLEAR_ARG: begin
            if (data_read && command == CMD_CLEAR && data_index == 16'd1) begin
              fill_byte <= data;
              cnt       <= '0;
              busy      <= 1'b1;
              state     <= FILL;
            end
          end
          FILL: begin
            if (cmd_ok)
              err_overrun <= 1'b1;
            w_en   <= 1'b1;
            w_addr <= pix_addr(sel, cnt);
            w_data <= swap_pix(fill_byte);
            cnt    <= cnt + 16'd1;
`ifdef SPRITE_LOAD_CHECKSUM_EN
            sum <= sum + fill_byte;
`endif
            if (cnt == LAST_CNT) begin
              sprite_valid[sel] <= 1'b1;
              load_done         <= 1'b1;
              busy              <= 1'b0;
              state             <= IDLE;
`ifdef SPRITE_LOAD_CHECKSUM_EN
              load_checksum <= sum + fill_byte;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_load_controller.sv
// Directed plus randomized bench for sprite_load_controller (16 slots, 8 bytes/sprite, 4-bit pixels).
module tb_sprite_load_controller;
  localparam int NUM   = 16;
  localparam int BYTES = 8;
  localparam logic [7:0] C_SAVE  = 8'h01;
  localparam logic [7:0] C_CLEAR = 8'h02;
`ifdef SPRITE_LOAD_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  command = '0;
  logic [7:0]  data = '0;
  logic [15:0] data_index = '0;
  logic        data_read = 1'b0;
  logic        w_en;
  logic [7:0]  w_addr;
  logic [7:0]  w_data;
  logic        busy;
  logic        load_done;
  logic [15:0] sprite_valid;
  logic        err_overrun;
  logic [7:0]  load_checksum;

  sprite_load_controller #(.SPRITE_NUM(NUM), .SPRITE_BYTES(BYTES), .PIXEL_BITS(4)) dut (
    .clock(clock), .reset(reset), .command(command), .data(data),
    .data_index(data_index), .data_read(data_read), .w_en(w_en), .w_addr(w_addr),
    .w_data(w_data), .busy(busy), .load_done(load_done), .sprite_valid(sprite_valid),
    .err_overrun(err_overrun), .load_checksum(load_checksum)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Observed activity
  int wq_addr[$];
  int wq_data[$];
  int done_cnt = 0;
  int busy_cnt = 0;
  int dbl_done = 0;
  logic [7:0] last_ck = '0;
  logic prev_done = 1'b0;

  // Reference model
  int ea[$];
  int ed[$];
  int exp_done = 0;
  logic [7:0] exp_ck = '0;
  logic [15:0] exp_valid = '0;
  logic exp_err = 1'b0;
  int pl[BYTES];

  always @(negedge clock) begin
    if (w_en) begin
      wq_addr.push_back(int'(w_addr));
      wq_data.push_back(int'(w_data));
    end
    if (load_done) begin
      done_cnt++;
      last_ck = load_checksum;
    end
    if (load_done && prev_done) dbl_done++;
    prev_done = load_done;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nib_swap(input int b);
    return ((b & 15) << 4) | ((b >> 4) & 15);
  endfunction

  function automatic int addr_of(input int slot, input int k);
    return (slot * BYTES * 2 + k * 2) % 256;
  endfunction

  task automatic clear_obs();
    wq_addr.delete(); wq_data.delete();
    ea.delete(); ed.delete();
    done_cnt = 0; busy_cnt = 0; exp_done = 0;
  endtask

  task automatic send(input int c, input int i, input int d);
    command = 8'(c); data_index = 16'(i); data = 8'(d); data_read = 1'b1;
    @(negedge clock);
    data_read = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic settle();
    repeat (12) @(negedge clock);
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_w_en"}, 32'(w_en), 0);
    chk({tag, "_w_addr"}, 32'(w_addr), 0);
    chk({tag, "_w_data"}, 32'(w_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_valid"}, 32'(sprite_valid), 0);
    chk({tag, "_err"}, 32'(err_overrun), 0);
    chk({tag, "_ck"}, 32'(load_checksum), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    exp_valid = '0; exp_err = 1'b0;
    clear_obs();
  endtask

  // Loads nbytes of pl[] into slot; junk inserts an unknown-command strobe mid-stream.
  task automatic do_save(input int slot, input int nbytes, input bit junk);
    int sum = 0;
    send(C_SAVE, 0, slot); gap();
    if (slot < NUM) exp_valid[slot] = 1'b0;
    else exp_err = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      if (junk && k == 2) send(8'h07, 0, 9);
      send(C_SAVE, k + 1, pl[k]); gap();
      if (slot < NUM) begin
        ea.push_back(addr_of(slot, k));
        ed.push_back(nib_swap(pl[k]));
      end
      sum += pl[k];
    end
    if (slot < NUM && nbytes == BYTES) begin
      exp_valid[slot] = 1'b1;
      exp_done++;
      exp_ck = CK_EN ? 8'(sum % 256) : 8'd0;
    end
  endtask

  task automatic do_fill(input int slot, input int b, input bit poke);
    send(C_CLEAR, 0, slot); gap();
    send(C_CLEAR, 1, b);
    if (poke) begin
      repeat (2) @(negedge clock);
      send(C_SAVE, 3, 8'h77);
      exp_err = 1'b1;
    end
    for (int k = 0; k < BYTES; k++) begin
      ea.push_back(addr_of(slot, k));
      ed.push_back(nib_swap(b));
    end
    exp_valid[slot] = 1'b1;
    exp_done++;
    exp_ck = CK_EN ? 8'((b * BYTES) % 256) : 8'd0;
  endtask

  task automatic verify(input string tag);
    int n;
    chk({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(ea.size()));
    n = (wq_addr.size() < ea.size()) ? wq_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), 32'(ea[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(wq_data[i]), 32'(ed[i]));
    end
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    if (exp_done > 0) chk({tag, "_ck"}, 32'(last_ck), 32'(exp_ck));
    chk({tag, "_valid"}, 32'(sprite_valid), 32'(exp_valid));
    chk({tag, "_err"}, 32'(err_overrun), 32'(exp_err));
    chk({tag, "_dbl_done"}, 32'(dbl_done), 0);
    clear_obs();
  endtask

  initial begin
    reset_pulse("rst0");

    // Slot 3 load with a known byte ramp
    for (int k = 0; k < BYTES; k++) pl[k] = 'h12 + k * 'h22;
    do_save(3, BYTES, 1'b0);
    settle();
    chk("plan_first_addr", 32'(wq_addr.size() > 0 ? wq_addr[0] : -1), 48);
    chk("plan_first_data", 32'(wq_data.size() > 0 ? wq_data[0] : -1), 'h21);
    chk("plan_last_addr", 32'(wq_addr.size() > 0 ? wq_addr[wq_addr.size()-1] : -1), 62);
    verify("save3");

    // Fill slot 5 with 0xAB
    do_fill(5, 'hAB, 1'b0);
    settle();
    chk("fill5_busy_cycles", 32'(busy_cnt), 8);
    verify("fill5");

    // Checksum pattern 1..8
    for (int k = 0; k < BYTES; k++) pl[k] = k + 1;
    do_save(6, BYTES, 1'b0);
    settle();
    verify("ck_save6");

    // Restart mid-load: slot 7 loses its valid flag, slot 9 completes
    for (int k = 0; k < BYTES; k++) pl[k] = $urandom_range(0, 255);
    do_save(7, BYTES, 1'b0);
    do_save(7, 3, 1'b0);
    do_save(9, BYTES, 1'b0);
    settle();
    verify("restart");

    // Randomized loads and fills with ignored-command noise
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < BYTES; k++) pl[k] = $urandom_range(0, 255);
      if ($urandom_range(0, 2) == 0) do_fill($urandom_range(0, NUM - 1), $urandom_range(0, 255), 1'b0);
      else do_save($urandom_range(0, NUM - 1), BYTES, 1'($urandom_range(0, 1)));
      settle();
      verify($sformatf("rand%0d", it));
    end

    // Reset in the middle of a slot-3 load
    for (int k = 0; k < BYTES; k++) pl[k] = $urandom_range(0, 255);
    do_save(3, BYTES, 1'b0);
    settle();
    verify("pre_abort");
    do_save(3, 4, 1'b0);
    repeat (2) @(negedge clock);
    verify("partial3");
    reset_pulse("rst_mid");
    chk("abort_valid3", 32'(sprite_valid[3]), 0);
    do_save(3, BYTES, 1'b0);
    settle();
    verify("reload3");

    // data_read during a fill of slot 1
    do_fill(1, $urandom_range(0, 255), 1'b1);
    settle();
    verify("fill_poke");

    // Out-of-range slot after a good load
    reset_pulse("rst_oor");
    for (int k = 0; k < BYTES; k++) pl[k] = $urandom_range(0, 255);
    do_save(2, BYTES, 1'b0);
    settle();
    verify("save2");
    do_save(20, BYTES, 1'b0);
    settle();
    verify("slot20");

    // Payload index past the sprite end while idle
    reset_pulse("rst_idx");
    do_save(4, BYTES, 1'b0);
    settle();
    verify("save4");
    send(C_SAVE, BYTES + 1, 8'h11);
    exp_err = 1'b1;
    settle();
    verify("idx_over");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_load_controller.md
Name: sprite_load_controller

Overview:
- Parametrised successor to the SPI sprite write controller. Turns the SPI command byte stream into write-port cycles for sprite storage.
- Supports generic pixel depth, sprite count and sprite size.
- Adds an autonomous clear/fill mode, per-sprite valid tracking, completion pulses and overrun detection.
- Sits between the SPI slave decoder and sprite storage.

Parameters:
- SPRITE_NUM, 16, number of sprite slots.
- SPRITE_BYTES, 512, payload bytes per sprite.
- PIXEL_BITS, 4, bits per pixel; legal values are 4 or 8. PPB = 8/PIXEL_BITS pixels per byte.
- CMD_SAVE, 8'h01, command code for a streamed sprite load.
- CMD_CLEAR, 8'h02, command code for a fill of one sprite with a constant byte.
- ADDR_W, $clog2(SPRITE_NUM*SPRITE_BYTES*PPB), width of the pixel-unit write address.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- command  in  8  current SPI command byte.
- data  in  8  current SPI data byte.
- data_index  in  16  byte index within the command payload.
- data_read  in  1  one-cycle strobe: data/data_index valid.
- w_en  out  1  storage write enable, one-cycle pulse per byte.
- w_addr  out  ADDR_W  pixel-unit storage address.
- w_data  out  8  storage write byte.
- busy  out  1  high while in FILL.
- load_done  out  1  one-cycle pulse when a sprite completes.
- sprite_valid  out  SPRITE_NUM  per-slot complete flag.
- err_overrun  out  1  sticky error flag; cleared only by reset.
- load_checksum  out  8  see Optional Feature.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - w_en=0, w_addr=0, w_data=0, busy=0, load_done=0, sprite_valid=0, err_overrun=0, load_checksum=0.
  - Reset during LOAD or FILL aborts the operation; no partial-valid state survives.
- All outputs are registered. A write appears one clock after the accepting data_read.
- data_read with a command other than CMD_SAVE/CMD_CLEAR is ignored in every state.
- Address for payload byte k (k = data_index-1, or the fill counter) in slot s:
  - w_addr = s*SPRITE_BYTES*PPB + k*PPB, truncated to ADDR_W.
- w_data:
  - PIXEL_BITS=4: {byte[3:0], byte[7:4]}, so the first pixel lands in the upper nibble.
  - PIXEL_BITS=8: byte unchanged.
- States:
  - IDLE: data_read, index 0:
    - CMD_SAVE: latch sel=data.
      - If data < SPRITE_NUM: clear sprite_valid[sel], go to LOAD.
      - Otherwise: set err_overrun, go to DISCARD.
    - CMD_CLEAR: latch sel with the same range check, go to CLEAR_ARG.
  - LOAD: data_read, CMD_SAVE, index in 1..SPRITE_BYTES: issue a write.
    - At index == SPRITE_BYTES: set sprite_valid[sel], pulse load_done, go to IDLE.
    - Index > SPRITE_BYTES cannot occur in LOAD (LOAD exits at SPRITE_BYTES).
    - Index 0 restarts with a new select; the old slot stays invalid.
  - CLEAR_ARG: data_read, index 1: latch fill byte, cnt=0, busy=1, go to FILL.
    - Index 0 restarts select.
  - FILL: one write per clock for cnt = 0..SPRITE_BYTES-1.
    - After the last write: set sprite_valid[sel], pulse load_done, busy=0, go to IDLE.
    - Any data_read during FILL is dropped and sets err_overrun.
  - DISCARD: ignore everything until data_read with index 0 and CMD_SAVE/CMD_CLEAR, then handle it as in IDLE.
- Payload bytes with index > SPRITE_BYTES arriving in IDLE after a completed load set err_overrun; no write is issued.
- load_done and w_en never stay high for more than one cycle per event.

Optional Feature:
- Macro SPRITE_LOAD_CHECKSUM_EN.
- Defined:
  - Running 8-bit modulo-256 sum of all payload bytes written (pre-swap) for the current sprite. Fill bytes count SPRITE_BYTES times.
  - Cleared at each index 0.
  - Copied to load_checksum in the same cycle as load_done.
- Undefined: load_checksum tied to 0 and no accumulator logic.

Test Plan:
(Bench uses SPRITE_NUM=16, SPRITE_BYTES=8, PIXEL_BITS=4.)
- Reset, then CMD_SAVE index0 data=3 followed by bytes 0x12,0x34,... at index 1..8 -> eight w_en pulses; first write w_addr=48, w_data=0x21; last write w_addr=62; load_done pulses once; sprite_valid=0x0008.
- CMD_CLEAR index0 data=5, index1 data=0xAB -> busy=1 for 8 clocks; w_data=0xBA each cycle at addresses 80,82,...,94; then load_done pulses and sprite_valid[5]=1.
- CMD_SAVE index0 data=20 followed by payload -> err_overrun=1; no w_en pulses; sprite_valid unchanged.
- CMD_SAVE to slot 3 and assert reset after byte 4 -> all outputs 0 immediately; sprite_valid[3]=0; a subsequent full load of slot 3 succeeds.
- data_read during FILL of slot 1 -> the byte is dropped, err_overrun=1, and the fill still completes all 8 writes.
- With SPRITE_LOAD_CHECKSUM_EN, load bytes 1..8 -> load_checksum=0x24 when load_done pulses.
